// File: rtl/fifo512x8_pkg.sv
// Shared sizing constants and a pointer helper for the 512x8 byte FIFO.
package fifo512x8_pkg;

    localparam int DEPTH = 512;   // bytes of storage
    localparam int AW    = 9;     // RAM address / pointer width
    localparam int DW    = 8;     // data width
    localparam int CW    = 10;    // occupancy counter width (0..512)

    // Pointers are exactly AW bits wide, so the increment wraps 511 -> 0 on its own.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/SB_RAM512x8.sv
// Behavioural model of the 512x8 block RAM wrapper: registered read, masked write.
module SB_RAM512x8
    import fifo512x8_pkg::*;
(
    output logic [DW-1:0] RDATA,
    input  logic [AW-1:0] RADDR,
    input  logic          RCLK,
    input  logic          RCLKE,
    input  logic          RE,
    input  logic [AW-1:0] WADDR,
    input  logic          WCLK,
    input  logic          WCLKE,
    input  logic [DW-1:0] WDATA,
    input  logic          WE,
    input  logic [DW-1:0] MASK
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port: a set MASK bit keeps the stored bit.
    always_ff @(posedge WCLK) begin
        if (WCLKE && WE) begin
            mem[WADDR] <= (WDATA & ~MASK) | (mem[WADDR] & MASK);
        end
    end

    // Read port: output register only loads on a read, otherwise it holds.
    always_ff @(posedge RCLK) begin
        if (RCLKE && RE) begin
            rdata_q <= mem[RADDR];
        end
    end

    assign RDATA = rdata_q;

endmodule

// File: rtl/fifo512x8.sv
// 512-deep byte FIFO around a single block RAM, with registered status flags
// and sticky overflow/underflow error bits.
module fifo512x8
    import fifo512x8_pkg::*;
#(
    parameter int AFULL_LEVEL  = 448,
    parameter int AEMPTY_LEVEL = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] AFULL_LV  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_LV = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0] DEPTH_LV  = CW'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_valid_q, rd_valid_d;
    // Set once the RAM output register holds a genuinely popped byte; until
    // then rd_data is forced to zero so stale RAM output never leaks out.
    logic          data_seen_q, data_seen_d;

    logic          push;
    logic          pop;
    logic [DW-1:0] ram_rdata;

    // Accept decisions use the flags registered at the start of the cycle;
    // reset blocks both so the RAM is neither written nor read.
    always_comb begin
        push = wr_en & ~full_q  & ~reset;
        pop  = rd_en & ~empty_q & ~reset;
    end

    // Next-state for pointers, occupancy, flags and error bits.
    always_comb begin
        wptr_d      = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d      = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        full_d      = (count_d == DEPTH_LV);
        empty_d     = (count_d == '0);
        afull_d     = (count_d >= AFULL_LV);
        aempty_d    = (count_d <= AEMPTY_LV);
        overflow_d  = overflow_q  | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
        rd_valid_d  = pop;
        data_seen_d = data_seen_q | pop;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            data_seen_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            data_seen_q <= data_seen_d;
        end
    end

    // When push and pop are both accepted the FIFO holds 1..511 bytes, so
    // the two RAM addresses always differ and no bypass path is required.
    SB_RAM512x8 u_ram (
        .RDATA (ram_rdata),
        .RADDR (rptr_q),
        .RCLK  (clk),
        .RCLKE (1'b1),
        .RE    (pop),
        .WADDR (wptr_q),
        .WCLK  (clk),
        .WCLKE (1'b1),
        .WDATA (wr_data),
        .WE    (push),
        .MASK  ({DW{1'b0}})
    );

    // The RAM output register holds between pops, giving rd_data its hold behaviour.
    always_comb begin
        rd_data = data_seen_q ? ram_rdata : '0;
    end

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
